// File: rtl/floo_id_order_tracker.sv
// Per-ID ordering gate for the NoRoB chimney request path: a request on an ID is
// admitted only if that ID is idle or all its in-flight traffic goes to the same destination.
module floo_id_order_tracker #(
  parameter int unsigned NumIds       = 16,
  parameter int unsigned MaxTxnsPerId = 16,
  parameter int unsigned NumX         = 4,
  parameter int unsigned NumY         = 4,
  localparam int unsigned IdWidth     = $clog2(NumIds),
  localparam int unsigned CntWidth    = $clog2(MaxTxnsPerId + 1),
  localparam int unsigned XWidth      = $clog2(NumX),
  localparam int unsigned YWidth      = $clog2(NumY),
  localparam int unsigned DstWidth    = XWidth + YWidth
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [IdWidth-1:0]  req_id_i,
  input  logic [DstWidth-1:0] req_dst_i,
  output logic                req_valid_o,
  input  logic                req_ready_i,
  input  logic                rsp_valid_i,
  input  logic                rsp_ready_i,
  input  logic [IdWidth-1:0]  rsp_id_i,
  input  logic                last_rsp_i,
  output logic                stall_o,
  output logic                idle_o,
  output logic                err_o
);

  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxTxnsPerId);

  logic [CntWidth-1:0] cnt_q [NumIds];
  logic [DstWidth-1:0] dst_q [NumIds];
  logic                err_q;

  logic [CntWidth-1:0] req_cnt;
  logic [CntWidth-1:0] rsp_cnt;
  logic                allow;
  logic                req_fire;
  logic                rsp_fire;
  logic [NumIds-1:0]   inc;
  logic [NumIds-1:0]   dec;
  logic                idle;

  assign req_cnt = cnt_q[req_id_i];
  assign rsp_cnt = cnt_q[rsp_id_i];

  // Admission always looks at the pre-update count, so a same-cycle completion
  // cannot open the gate until the following cycle.
  assign allow = (req_cnt == '0) |
                 ((dst_q[req_id_i] == req_dst_i) & (req_cnt < MaxCnt));

  assign req_valid_o = req_valid_i & allow;
  assign req_ready_o = req_ready_i & allow;
  assign stall_o     = req_valid_i & ~allow;

  assign req_fire = req_valid_o & req_ready_i;
  assign rsp_fire = rsp_valid_i & rsp_ready_i & last_rsp_i;

  always_comb begin
    inc  = '0;
    dec  = '0;
    idle = 1'b1;
    for (int i = 0; i < NumIds; i++) begin
      inc[i] = req_fire & (req_id_i == IdWidth'(i));
      dec[i] = rsp_fire & (rsp_id_i == IdWidth'(i)) & (cnt_q[i] != '0);
      idle   = idle & (cnt_q[i] == '0);
    end
  end

  assign idle_o = idle;
  assign err_o  = err_q;

  // A completion on an ID with nothing outstanding is reported, never counted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
      for (int i = 0; i < NumIds; i++) begin
        cnt_q[i] <= '0;
        dst_q[i] <= '0;
      end
    end else begin
      err_q <= rsp_fire & (rsp_cnt == '0);
      for (int i = 0; i < NumIds; i++) begin
        if (inc[i] && !dec[i]) begin
          cnt_q[i] <= cnt_q[i] + CntWidth'(1);
        end else if (dec[i] && !inc[i]) begin
          cnt_q[i] <= cnt_q[i] - CntWidth'(1);
        end
        if (inc[i]) begin
          dst_q[i] <= req_dst_i;
        end
      end
    end
  end

  for (genvar g = 0; g < NumIds; g++) begin : gen_cnt_bound
    cnt_bound_a : assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_q[g] <= MaxCnt);
  end

endmodule

// File: tb/tb_floo_id_order_tracker.sv
// Directed bench for floo_id_order_tracker: a vector table for the ordering
// scenarios plus hand sequences for the full-burst limit and mid-traffic reset.
module tb_floo_id_order_tracker;

  logic       clk;
  logic       rst_ni;
  logic       req_valid_i;
  logic       req_ready_o;
  logic [3:0] req_id_i;
  logic [3:0] req_dst_i;
  logic       req_valid_o;
  logic       req_ready_i;
  logic       rsp_valid_i;
  logic       rsp_ready_i;
  logic [3:0] rsp_id_i;
  logic       last_rsp_i;
  logic       stall_o;
  logic       idle_o;
  logic       err_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       rv;
    logic       rr;
    logic [3:0] id;
    logic [3:0] dst;
    logic       sv;
    logic       sr;
    logic [3:0] sid;
    logic       lst;
    logic       ev;
    logic       er;
    logic       es;
    logic       ei;
    logic       ee;
  } vec_t;

  vec_t vecs [23];

  floo_id_order_tracker dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_id_i    (req_id_i),
    .req_dst_i   (req_dst_i),
    .req_valid_o (req_valid_o),
    .req_ready_i (req_ready_i),
    .rsp_valid_i (rsp_valid_i),
    .rsp_ready_i (rsp_ready_i),
    .rsp_id_i    (rsp_id_i),
    .last_rsp_i  (last_rsp_i),
    .stall_o     (stall_o),
    .idle_o      (idle_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rv, input logic rr, input logic [3:0] id,
                              input logic [3:0] dst, input logic sv, input logic sr,
                              input logic [3:0] sid, input logic lst, input logic ev,
                              input logic er, input logic es, input logic ei, input logic ee);
    vec_t v;
    v = '{rv, rr, id, dst, sv, sr, sid, lst, ev, er, es, ei, ee};
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    req_valid_i = v.rv;
    req_ready_i = v.rr;
    req_id_i    = v.id;
    req_dst_i   = v.dst;
    rsp_valid_i = v.sv;
    rsp_ready_i = v.sr;
    rsp_id_i    = v.sid;
    last_rsp_i  = v.lst;
  endtask

  task automatic checkOutput(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // One cycle: drive, compare the settled outputs at the falling edge, then clock.
  task automatic runVec(input vec_t v, input string name);
    applyStimulus(v);
    @(negedge clk);
    checkOutput({name, ".req_valid_o"}, req_valid_o, v.ev);
    checkOutput({name, ".req_ready_o"}, req_ready_o, v.er);
    checkOutput({name, ".stall_o"}, stall_o, v.es);
    checkOutput({name, ".idle_o"}, idle_o, v.ei);
    checkOutput({name, ".err_o"}, err_o, v.ee);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // dst encoding {y,x}: {0,1}=1 {1,1}=5 {1,2}=6 {2,2}=10 {3,3}=15
    vecs[0]  = mk(1,1,5,1,  0,0,0,0, 1,1,0,1,0);
    vecs[1]  = mk(1,1,5,1,  0,0,0,0, 1,1,0,0,0);
    vecs[2]  = mk(1,1,5,15, 0,0,0,0, 0,0,1,0,0);
    vecs[3]  = mk(1,1,5,15, 1,1,5,1, 0,0,1,0,0);
    vecs[4]  = mk(1,1,5,15, 1,1,5,1, 0,0,1,0,0);
    vecs[5]  = mk(1,1,5,15, 0,0,0,0, 1,1,0,1,0);
    vecs[6]  = mk(1,0,5,15, 0,0,0,0, 1,0,0,0,0);
    vecs[7]  = mk(0,0,0,0,  1,1,5,1, 0,0,0,0,0);
    vecs[8]  = mk(0,0,0,0,  0,0,0,0, 0,0,0,1,0);
    vecs[9]  = mk(1,1,0,0,  0,0,0,0, 1,1,0,1,0);
    vecs[10] = mk(1,1,1,10, 0,0,0,0, 1,1,0,0,0);
    vecs[11] = mk(0,0,0,0,  1,1,0,1, 0,0,0,0,0);
    vecs[12] = mk(0,0,0,0,  1,0,1,1, 0,0,0,0,0);
    vecs[13] = mk(0,0,0,0,  1,1,1,1, 0,0,0,0,0);
    vecs[14] = mk(0,0,0,0,  0,0,0,0, 0,0,0,1,0);
    vecs[15] = mk(1,1,7,5,  0,0,0,0, 1,1,0,1,0);
    vecs[16] = mk(1,1,7,5,  1,1,7,1, 1,1,0,0,0);
    vecs[17] = mk(0,0,0,0,  1,1,7,0, 0,0,0,0,0);
    vecs[18] = mk(0,0,0,0,  1,1,7,1, 0,0,0,0,0);
    vecs[19] = mk(0,0,0,0,  0,0,0,0, 0,0,0,1,0);
    vecs[20] = mk(0,0,0,0,  1,1,9,1, 0,0,0,1,0);
    vecs[21] = mk(0,0,0,0,  0,0,0,0, 0,0,0,1,1);
    vecs[22] = mk(0,0,0,0,  0,0,0,0, 0,0,0,1,0);

    rst_ni = 1'b0;
    applyStimulus(mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0));
    #1;
    checkOutput("reset.idle_o", idle_o, 1'b1);
    checkOutput("reset.err_o", err_o, 1'b0);
    checkOutput("reset.req_valid_o", req_valid_o, 1'b0);
    checkOutput("reset.stall_o", stall_o, 1'b0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;

    for (int i = 0; i < 23; i++) begin
      runVec(vecs[i], $sformatf("vec%0d", i));
    end

    // Sixteen requests fill ID 3; the seventeenth waits for a completion.
    for (int k = 0; k < 16; k++) begin
      runVec(mk(1,1,3,6, 0,0,0,0, 1,1,0,(k == 0),0), $sformatf("burst%0d", k));
    end
    runVec(mk(1,1,3,6, 0,0,0,0, 0,0,1,0,0), "burst_full");
    runVec(mk(1,1,3,6, 1,1,3,1, 0,0,1,0,0), "burst_full_rsp");
    runVec(mk(1,1,3,6, 0,0,0,0, 1,1,0,0,0), "burst_17th");
    for (int k = 0; k < 16; k++) begin
      runVec(mk(0,0,0,0, 1,1,3,1, 0,0,0,0,0), $sformatf("drain%0d", k));
    end
    runVec(mk(0,0,0,0, 0,0,0,0, 0,0,0,1,0), "drain_idle");

    // Reset in the middle of traffic, with an error pulse live.
    for (int k = 0; k < 4; k++) begin
      runVec(mk(1,1,2,3, 0,0,0,0, 1,1,0,(k == 0),0), $sformatf("rst_fill%0d", k));
    end
    runVec(mk(0,0,0,0, 1,1,9,1, 0,0,0,0,0), "rst_underflow");
    checkOutput("rst_pre.err_o", err_o, 1'b1);
    checkOutput("rst_pre.idle_o", idle_o, 1'b0);
    #1;
    rst_ni = 1'b0;
    #1;
    checkOutput("rst_async.idle_o", idle_o, 1'b1);
    checkOutput("rst_async.err_o", err_o, 1'b0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    runVec(mk(0,0,0,0, 1,1,2,1, 0,0,0,1,0), "post_rst_rsp");
    runVec(mk(0,0,0,0, 0,0,0,0, 0,0,0,1,1), "post_rst_err");
    runVec(mk(0,0,0,0, 0,0,0,0, 0,0,0,1,0), "post_rst_err_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
